// File: rtl/master_axi_test_pkg.sv
// rtl/master_axi_test_pkg.sv - shared types and helpers for the master_axi_test stream stage
package master_axi_test_pkg;

    // Source-side start-up sequencing
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_SEND = 2'd2
    } src_state_t;

    localparam int unsigned DEF_TDATA_W = 32;

    // Default-width beat; the top re-declares the same layout at its configured width
    typedef struct packed {
        logic [DEF_TDATA_W-1:0]   tdata;
        logic [DEF_TDATA_W/8-1:0] tstrb;
        logic                     tlast;
    } axis_beat_t;

    // Occupancy counters need one extra bit so that "full" is representable
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// rtl/axis_sync_fifo.sv - single-clock beat FIFO with occupancy count and full/empty flags
module axis_sync_fifo
    import master_axi_test_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter type         beat_t = axis_beat_t
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  beat_t                      push_beat,
    input  logic                       pop,
    output beat_t                      head,
    output logic                       full,
    output logic                       empty,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    beat_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array: written on accepted pushes only, never reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_beat;
        end
    end

    // Pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/master_axi_test.sv
// rtl/master_axi_test.sv - AXI4-Stream buffer stage with start delay; MASTER_AXI_TEST_STORE_FWD_EN selects store-and-forward
module master_axi_test
    import master_axi_test_pkg::*;
#(
    parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned C_M00_AXIS_START_COUNT = 32,
    parameter int unsigned C_FIFO_DEPTH           = 16
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_aresetn,
    input  logic                                  m00_axis_aclk,
    input  logic                                  m00_axis_aresetn,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
    input  logic                                  s00_axis_tlast,
    input  logic                                  s00_axis_tvalid,
    output logic                                  s00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                                  m00_axis_tlast,
    output logic                                  m00_axis_tvalid,
    input  logic                                  m00_axis_tready
);

    localparam int unsigned DW = C_S00_AXIS_TDATA_WIDTH;
    localparam int unsigned CW = cnt_width(C_FIFO_DEPTH);
    localparam logic [31:0] START_LAST = (C_M00_AXIS_START_COUNT == 0) ? 32'd0
                                         : 32'(C_M00_AXIS_START_COUNT - 1);

    if (C_S00_AXIS_TDATA_WIDTH != C_M00_AXIS_TDATA_WIDTH) begin : g_width_check
        $error("master_axi_test: sink and source data widths must match");
    end
    if (C_FIFO_DEPTH < 2 || (C_FIFO_DEPTH & (C_FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("master_axi_test: C_FIFO_DEPTH must be a power of two and at least 2");
    end

    typedef struct packed {
        logic [DW-1:0]   tdata;
        logic [DW/8-1:0] tstrb;
        logic            tlast;
    } beat_t;

    src_state_t     state;
    logic [31:0]    delay_cnt;
    beat_t          in_beat;
    beat_t          head;
    logic           full;
    logic           empty;
    logic [CW-1:0]  count;
    logic           push;
    logic           pop;
    logic           fwd_ok;
    logic           unused_ports;

    // The source-side clock/reset are the same nets as the sink side
    assign unused_ports = m00_axis_aclk ^ m00_axis_aresetn ^ (|count);

    assign in_beat         = '{tdata: s00_axis_tdata, tstrb: s00_axis_tstrb, tlast: s00_axis_tlast};
    assign s00_axis_tready = s00_axis_aresetn && !full;
    assign push            = s00_axis_tvalid && s00_axis_tready;
    assign m00_axis_tvalid = (state == ST_SEND) && !empty && fwd_ok;
    assign pop             = m00_axis_tvalid && m00_axis_tready;
    assign m00_axis_tdata  = m00_axis_tvalid ? head.tdata : '0;
    assign m00_axis_tstrb  = m00_axis_tvalid ? head.tstrb : '0;
    assign m00_axis_tlast  = m00_axis_tvalid ? head.tlast : 1'b0;

    axis_sync_fifo #(
        .DEPTH  (C_FIFO_DEPTH),
        .beat_t (beat_t)
    ) u_fifo (
        .clk       (s00_axis_aclk),
        .resetn    (s00_axis_aresetn),
        .push      (push),
        .push_beat (in_beat),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // Start-delay sequencer: IDLE -> INIT (counts START_COUNT cycles) -> SEND until reset
    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            state     <= ST_IDLE;
            delay_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    delay_cnt <= '0;
                    state     <= (C_M00_AXIS_START_COUNT == 0) ? ST_SEND : ST_INIT;
                end
                ST_INIT: begin
                    if (delay_cnt == START_LAST) begin
                        state <= ST_SEND;
                    end else begin
                        delay_cnt <= delay_cnt + 32'd1;
                    end
                end
                default: state <= ST_SEND;
            endcase
        end
    end

`ifdef MASTER_AXI_TEST_STORE_FWD_EN
    logic [CW-1:0] pkt_cnt;
    logic          push_last;
    logic          pop_last;

    assign push_last = push && s00_axis_tlast;
    assign pop_last  = pop && head.tlast;
    // A full FIFO without any packet end must still drain, otherwise it deadlocks
    assign fwd_ok    = (pkt_cnt != '0) || full;

    // Complete packets currently buffered
    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            pkt_cnt <= '0;
        end else if (push_last && !pop_last) begin
            pkt_cnt <= pkt_cnt + CW'(1);
        end else if (pop_last && !push_last) begin
            pkt_cnt <= pkt_cnt - CW'(1);
        end
    end
`else
    assign fwd_ok = 1'b1;
`endif

endmodule

// File: tb/tb_master_axi_test.sv
// tb/tb_master_axi_test.sv - randomized scoreboard bench for master_axi_test
module tb_master_axi_test;

    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int SC    = 32;
    localparam int DEPTH = 16;

    typedef logic [DW+SW:0] beat_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic [SW-1:0] s_tstrb = '0;
    logic          s_tlast = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic [SW-1:0] m_tstrb;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready = 1'b1;

    beat_t sb_q[$];
    int    checks = 0;
    int    errors = 0;
    int    rel_cyc = -1;
    logic  prev_rstn = 1'b1;
    int    m_mode = 0;
    int    n_in = 0;
    int    n_out = 0;
    logic  exp_ready;
    logic  exp_valid;

    always #5 clk = ~clk;

    master_axi_test #(
        .C_S00_AXIS_TDATA_WIDTH (DW),
        .C_M00_AXIS_TDATA_WIDTH (DW),
        .C_M00_AXIS_START_COUNT (SC),
        .C_FIFO_DEPTH           (DEPTH)
    ) dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rstn),
        .m00_axis_aclk    (clk),
        .m00_axis_aresetn (rstn),
        .s00_axis_tdata   (s_tdata),
        .s00_axis_tstrb   (s_tstrb),
        .s00_axis_tlast   (s_tlast),
        .s00_axis_tvalid  (s_tvalid),
        .s00_axis_tready  (s_tready),
        .m00_axis_tdata   (m_tdata),
        .m00_axis_tstrb   (m_tstrb),
        .m00_axis_tlast   (m_tlast),
        .m00_axis_tvalid  (m_tvalid),
        .m00_axis_tready  (m_tready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit fwd_allowed();
`ifdef MASTER_AXI_TEST_STORE_FWD_EN
        if (sb_q.size() == DEPTH) return 1'b1;
        foreach (sb_q[i]) if (sb_q[i][0]) return 1'b1;
        return 1'b0;
`else
        return 1'b1;
`endif
    endfunction

    // Reference model and checker: an ordered queue of accepted beats plus the start-delay rule
    always @(negedge clk) begin
        if (!rstn) begin
            check("s_tready_in_reset", 64'(s_tready), 64'd0);
            if (!prev_rstn) check("m_tvalid_in_reset", 64'(m_tvalid), 64'd0);
            sb_q.delete();
            rel_cyc = -1;
        end else begin
            rel_cyc++;
            exp_ready = (sb_q.size() < DEPTH);
            exp_valid = (rel_cyc >= 1 + SC) && (sb_q.size() > 0) && fwd_allowed();
            check("s_tready", 64'(s_tready), 64'(exp_ready));
            check("m_tvalid", 64'(m_tvalid), 64'(exp_valid));
            if (m_tvalid && sb_q.size() > 0)
                check("m_beat", 64'({m_tdata, m_tstrb, m_tlast}), 64'(sb_q[0]));
            else if (!m_tvalid)
                check("m_idle_zero", 64'({m_tdata, m_tstrb, m_tlast}), 64'd0);
            if (m_tvalid && exp_valid && m_tready) begin
                void'(sb_q.pop_front());
                n_out++;
            end
            if (s_tvalid && exp_ready) begin
                sb_q.push_back({s_tdata, s_tstrb, s_tlast});
                n_in++;
            end
        end
        prev_rstn = rstn;
    end

    // Sink-side ready pattern generator
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (m_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = 1'b0;
                2:       m_tready = ~m_tready;
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one beat, hold it until accepted; data is scrambled while tvalid is low
    task automatic send_beat(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l, input int gap);
        int budget;
        bit done;
        step(gap);
        s_tdata  = d;
        s_tstrb  = s;
        s_tlast  = l;
        s_tvalid = 1'b1;
        budget   = 0;
        done     = 1'b0;
        while (!done && budget < 300) begin
            @(negedge clk);
            done = s_tready;
            @(posedge clk);
            #1;
            budget++;
        end
        if (!done) check("send_timeout", 64'd0, 64'd1);
        s_tvalid = 1'b0;
        s_tdata  = $urandom;
        s_tstrb  = SW'($urandom);
        s_tlast  = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int b = 0;
        while (sb_q.size() > 0 && b < 600) begin
            step(1);
            b++;
        end
        check("drain_timeout", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        int base;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step(40);

        for (int i = 0; i < 32; i++)
            send_beat(DW'(i), SW'(1), (i % 4) == 3, $urandom_range(0, 2));
        drain();

        m_mode = 1;
        step(2);
        base = n_in;
        fork
            for (int i = 0; i < 20; i++)
                send_beat($urandom, SW'($urandom), (i % 4) == 3, 0);
            begin
                step(40);
                check("accepted_while_blocked", 64'(n_in - base), 64'd16);
                check("s_tready_when_full", 64'(s_tready), 64'd0);
                m_mode = 0;
            end
        join
        drain();

        m_mode = 2;
        for (int i = 0; i < 40; i++)
            send_beat($urandom, SW'($urandom), (i == 39) || ($urandom_range(0, 3) == 0), $urandom_range(0, 1));
        drain();

        m_mode = 1;
        step(2);
        for (int i = 0; i < 5; i++)
            send_beat(DW'(32'hA000 + i), SW'(4'hF), i == 4, 0);
        step(2);
        check("valid_before_reset", 64'(m_tvalid), 64'd1);
        rstn = 1'b0;
        step(1);
        rstn   = 1'b1;
        m_mode = 3;
        for (int i = 0; i < 10; i++)
            send_beat($urandom, SW'($urandom), (i == 9) || ($urandom_range(0, 2) == 0), $urandom_range(0, 1));
        drain();
        step(4);

        check("total_beats_out", 64'(n_out), 64'd102);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
